// File: rtl/lan_spi_pkg.sv
// Shared definitions for the LAN SPI command sequencer: core register map,
// control word layout and state encodings.
package lan_spi_pkg;

    localparam logic [2:0] ADDR_DATA_RX = 3'd0;
    localparam logic [2:0] ADDR_DATA_TX = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned SSO_BIT      = 10;
    localparam int unsigned SHIFT_CYCLES = 90;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SS_ON,
        S_TX_WAIT,
        S_TX_WR,
        S_RX_WAIT,
        S_RX_RD,
        S_RX_PUSH,
        S_SS_OFF,
        S_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACT1,
        BUS_ACT2,
        BUS_GAP
    } bus_state_e;

    typedef enum logic [1:0] {
        BYTE_OP,
        BYTE_DUMMY,
        BYTE_PAYLOAD
    } byte_kind_e;

    function automatic logic [15:0] control_word(input logic sso);
        logic [15:0] w;
        w          = '0;
        w[SSO_BIT] = sso;
        return w;
    endfunction

endpackage

// File: rtl/lan_spi_bus_access.sv
// One register access on the SPI core port: two strobed cycles then one idle
// cycle, so the core never sees a strobe long enough to re-trigger.
module lan_spi_bus_access
    import lan_spi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        rd_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        rdata_valid_o,
    output logic [15:0] rdata_o,
    input  logic [15:0] spi_rdata_i,
    output logic        spi_select_o,
    output logic        spi_read_n_o,
    output logic        spi_write_n_o,
    output logic [2:0]  spi_addr_o,
    output logic [15:0] spi_wdata_o
);

    bus_state_e  state_q;
    logic        rd_q;
    logic        select_q;
    logic        read_n_q;
    logic        write_n_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        rvalid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= BUS_IDLE;
            rd_q      <= 1'b0;
            select_q  <= 1'b0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                BUS_IDLE: begin
                    if (start_i) begin
                        select_q  <= 1'b1;
                        read_n_q  <= !rd_i;
                        write_n_q <= rd_i;
                        addr_q    <= addr_i;
                        wdata_q   <= rd_i ? '0 : wdata_i;
                        rd_q      <= rd_i;
                        state_q   <= BUS_ACT1;
                    end
                end
                BUS_ACT1: state_q <= BUS_ACT2;
                BUS_ACT2: begin
                    // Read data is captured on the edge that ends the second strobe cycle.
                    select_q  <= 1'b0;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    if (rd_q) begin
                        rdata_q  <= spi_rdata_i;
                        rvalid_q <= 1'b1;
                    end
                    state_q <= BUS_GAP;
                end
                BUS_GAP:  state_q <= BUS_IDLE;
                default:  state_q <= BUS_IDLE;
            endcase
        end
    end

    assign busy_o        = start_i || (state_q != BUS_IDLE);
    assign rdata_valid_o = rvalid_q;
    assign rdata_o       = rdata_q;
    assign spi_select_o  = select_q;
    assign spi_read_n_o  = read_n_q;
    assign spi_write_n_o = write_n_q;
    assign spi_addr_o    = addr_q;
    assign spi_wdata_o   = wdata_q;

endmodule

// File: rtl/lan_spi_cmd_seq.sv
// Command sequencer: turns one framed SPI transaction (opcode, optional dummy,
// payload) into single-byte-in-flight register accesses on the SPI core.
module lan_spi_cmd_seq
    import lan_spi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned LEN_W          = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_op,
    input  logic             cmd_dummy,
    input  logic             cmd_rd,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             spi_select,
    output logic             spi_read_n,
    output logic             spi_write_n,
    output logic [2:0]       spi_addr,
    output logic [15:0]      spi_wdata,
    input  logic [15:0]      spi_rdata,
    input  logic             spi_trdy,
    input  logic             spi_rrdy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e       state_q;
    byte_kind_e       kind_q;
    logic             cmd_ready_q, busy_q, done_q, err_q, tmo_err_q;
    logic             tx_ready_q, rx_valid_q, issued_q;
    logic [7:0]       rx_data_q, op_q;
    logic             dummy_q, rd_q;
    logic [LEN_W-1:0] rem_q;
    logic [TMO_W-1:0] tmo_q;
    logic             start_q, bus_rd_q;
    logic [2:0]       bus_addr_q;
    logic [15:0]      bus_wdata_q;

    logic             bus_busy, bus_rvalid;
    logic [15:0]      bus_rdata;
    logic             unused_rdata_hi;

    byte_kind_e       kind_d;
    logic [LEN_W-1:0] rem_d;
    logic             last_byte_d, need_tx_d, tmo_hit_d;
    logic [7:0]       tx_byte_d;

    assign unused_rdata_hi = ^bus_rdata[15:8];

    always_comb begin
        kind_d      = BYTE_PAYLOAD;
        last_byte_d = 1'b0;
        case (kind_q)
            BYTE_OP: begin
                last_byte_d = !dummy_q && (rem_q == '0);
                kind_d      = dummy_q ? BYTE_DUMMY : BYTE_PAYLOAD;
            end
            BYTE_DUMMY: last_byte_d = (rem_q == '0);
            default:    last_byte_d = (rem_q == LEN_W'(1));
        endcase
        rem_d     = (kind_q == BYTE_PAYLOAD) ? rem_q - LEN_W'(1) : rem_q;
        need_tx_d = (kind_q == BYTE_PAYLOAD) && !rd_q;
        tx_byte_d = (kind_q == BYTE_OP) ? op_q : (need_tx_d ? tx_data : 8'h00);
        tmo_hit_d = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= BYTE_OP;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_err_q   <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            issued_q    <= 1'b0;
            op_q        <= '0;
            dummy_q     <= 1'b0;
            rd_q        <= 1'b0;
            rem_q       <= '0;
            tmo_q       <= '0;
            start_q     <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            start_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        op_q        <= cmd_op;
                        dummy_q     <= cmd_dummy;
                        rd_q        <= cmd_rd;
                        rem_q       <= cmd_len;
                        kind_q      <= BYTE_OP;
                        tmo_err_q   <= 1'b0;
                        start_q     <= 1'b1;
                        bus_rd_q    <= 1'b0;
                        bus_addr_q  <= ADDR_CONTROL;
                        bus_wdata_q <= control_word(1'b1);
                        state_q     <= S_SS_ON;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_SS_ON: begin
                    if (!bus_busy) begin
                        tmo_q   <= '0;
                        state_q <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (!bus_busy && spi_trdy && (!need_tx_d || tx_valid)) begin
                        start_q     <= 1'b1;
                        bus_rd_q    <= 1'b0;
                        bus_addr_q  <= ADDR_DATA_TX;
                        bus_wdata_q <= {8'h00, tx_byte_d};
                        tx_ready_q  <= need_tx_d;
                        state_q     <= S_TX_WR;
                    end else if (!(spi_trdy && need_tx_d && !tx_valid)) begin
                        // Waiting on the byte source alone never times out.
                        if (tmo_hit_d) begin
                            tmo_err_q <= 1'b1;
                            issued_q  <= 1'b0;
                            state_q   <= S_SS_OFF;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end
                S_TX_WR: begin
                    if (!bus_busy) begin
                        tmo_q   <= '0;
                        state_q <= S_RX_WAIT;
                    end
                end
                S_RX_WAIT: begin
                    if (spi_rrdy) begin
                        start_q     <= 1'b1;
                        bus_rd_q    <= 1'b1;
                        bus_addr_q  <= ADDR_DATA_RX;
                        bus_wdata_q <= '0;
                        state_q     <= S_RX_RD;
                    end else if (tmo_hit_d) begin
                        tmo_err_q <= 1'b1;
                        issued_q  <= 1'b0;
                        state_q   <= S_SS_OFF;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_RX_RD: begin
                    if (bus_rvalid) begin
                        if (kind_q == BYTE_PAYLOAD && rd_q) begin
                            rx_data_q  <= bus_rdata[7:0];
                            rx_valid_q <= 1'b1;
                            state_q    <= S_RX_PUSH;
                        end else begin
                            kind_q   <= kind_d;
                            rem_q    <= rem_d;
                            issued_q <= 1'b0;
                            tmo_q    <= '0;
                            state_q  <= last_byte_d ? S_SS_OFF : S_TX_WAIT;
                        end
                    end
                end
                S_RX_PUSH: begin
                    if (rx_ready) begin
                        rx_valid_q <= 1'b0;
                        kind_q     <= kind_d;
                        rem_q      <= rem_d;
                        issued_q   <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= last_byte_d ? S_SS_OFF : S_TX_WAIT;
                    end
                end
                S_SS_OFF: begin
                    if (!bus_busy) begin
                        if (!issued_q) begin
                            start_q     <= 1'b1;
                            bus_rd_q    <= 1'b0;
                            bus_addr_q  <= ADDR_CONTROL;
                            bus_wdata_q <= control_word(1'b0);
                            issued_q    <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= tmo_err_q;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q      <= 1'b0;
                    err_q       <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    lan_spi_bus_access u_bus (
        .clk_i         (clk),
        .rst_i         (reset),
        .start_i       (start_q),
        .rd_i          (bus_rd_q),
        .addr_i        (bus_addr_q),
        .wdata_i       (bus_wdata_q),
        .busy_o        (bus_busy),
        .rdata_valid_o (bus_rvalid),
        .rdata_o       (bus_rdata),
        .spi_rdata_i   (spi_rdata),
        .spi_select_o  (spi_select),
        .spi_read_n_o  (spi_read_n),
        .spi_write_n_o (spi_write_n),
        .spi_addr_o    (spi_addr),
        .spi_wdata_o   (spi_wdata)
    );

    assign cmd_ready = cmd_ready_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lan_spi_cmd_seq.sv
// Directed bench for lan_spi_cmd_seq with a small behavioural SPI core model
// and a bus monitor that logs every register write.
module tb_lan_spi_cmd_seq;
    import lan_spi_pkg::*;

    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_dummy, cmd_rd;
    logic [7:0]  cmd_op;
    logic [10:0] cmd_len;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic        busy, done, err;
    logic        spi_select, spi_read_n, spi_write_n, spi_trdy, spi_rrdy;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata, spi_rdata;

    always #5 clk = ~clk;

    lan_spi_cmd_seq #(.TIMEOUT_CYCLES(TMO), .LEN_W(11)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dummy(cmd_dummy), .cmd_rd(cmd_rd), .cmd_len(cmd_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .spi_select(spi_select), .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI core model: DATA_TX write starts a shift; its end raises rrdy with the next response byte.
    logic        hold_rrdy;
    logic [7:0]  resp [0:7];
    logic        sel_prev;
    int unsigned shift_cnt;
    int unsigned resp_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_trdy  <= 1'b1;
            spi_rrdy  <= 1'b0;
            spi_rdata <= '0;
            sel_prev  <= 1'b0;
            shift_cnt <= 0;
            resp_idx  <= 0;
        end else begin
            sel_prev <= spi_select;
            if (spi_select && !sel_prev) begin
                if (!spi_write_n && spi_addr == ADDR_DATA_TX) begin
                    spi_trdy  <= 1'b0;
                    shift_cnt <= SHIFT_CYCLES;
                end
                if (!spi_write_n && spi_addr == ADDR_CONTROL && spi_wdata[SSO_BIT])
                    resp_idx <= 0;
                if (!spi_read_n && spi_addr == ADDR_DATA_RX)
                    spi_rrdy <= 1'b0;
            end
            if (shift_cnt == 1) begin
                spi_trdy  <= 1'b1;
                spi_rrdy  <= !hold_rrdy;
                spi_rdata <= {8'h00, resp[resp_idx % 8]};
                resp_idx  <= resp_idx + 1;
            end
            if (shift_cnt != 0) shift_cnt <= shift_cnt - 1;
        end
    end

    logic [2:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    logic [7:0]  rx_log  [$];
    int unsigned run_len = 0;

    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else begin
            if (spi_select) begin
                if (run_len == 0 && !spi_write_n) begin
                    wr_addr.push_back(spi_addr);
                    wr_data.push_back(spi_wdata);
                end
                check_eq("strobe_one_hot", 32'(spi_read_n ^ spi_write_n), 32'd1);
                run_len++;
            end else if (run_len != 0) begin
                check_eq("strobe_len", run_len, 32'd2);
                run_len = 0;
            end
            if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        end
    end

    task automatic check_wlog(input string tag, input int unsigned base, input logic [18:0] exp [$]);
        check_eq({tag, "_nwr"}, 32'(wr_addr.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < wr_addr.size())
                check_eq($sformatf("%s_wr%0d", tag, i), {13'b0, wr_addr[base+i], wr_data[base+i]}, {13'b0, exp[i]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_flags"},
                 {23'b0, cmd_ready, tx_ready, rx_valid, busy, done, err, spi_select, spi_read_n, spi_write_n},
                 32'b011);
        check_eq({tag, "_addr"}, {29'b0, spi_addr}, 32'd0);
        check_eq({tag, "_wdata"}, {16'b0, spi_wdata}, 32'd0);
        check_eq({tag, "_rxdata"}, {24'b0, rx_data}, 32'd0);
    endtask

    task automatic issue(input logic [7:0] op, input logic dmy, input logic rd, input logic [10:0] len);
        logic acc;
        @(posedge clk); #1;
        cmd_op = op; cmd_dummy = dmy; cmd_rd = rd; cmd_len = len; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("cmd_accept", 32'(acc), 32'd1);
        @(negedge clk);
        check_eq("busy_after_accept", {30'b0, busy, cmd_ready}, 32'b10);
    endtask

    task automatic wait_done(input int unsigned max_cyc, input logic exp_err, output int unsigned elapsed);
        logic seen;
        seen    = 1'b0;
        elapsed = 0;
        for (int unsigned i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; elapsed = i + 1; break; end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) check_eq("done_err", 32'(err), 32'(exp_err));
    endtask

    task automatic feed_tx(input logic [31:0] bytes, input int unsigned n);
        logic ok;
        for (int unsigned i = 0; i < n; i++) begin
            tx_data  = bytes[8*i +: 8];
            tx_valid = 1'b1;
            ok       = 1'b0;
            for (int j = 0; j < 3000; j++) begin
                @(negedge clk);
                if (tx_ready) begin ok = 1'b1; break; end
            end
            check_eq($sformatf("tx_take%0d", i), 32'(ok), 32'd1);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base, rbase, el, bad;
        logic [7:0]  d0;
        logic        seen;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dummy = 1'b0; cmd_rd = 1'b0;
        cmd_len = '0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1; hold_rrdy = 1'b0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;

        // Reset values, and cmd_ready rising one edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_eq("cmd_ready_release", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("cmd_ready_rise", 32'(cmd_ready), 32'd1);

        // Write command: op 0x40 with two TX payload bytes.
        base = wr_addr.size(); rbase = rx_log.size();
        issue(8'h40, 1'b0, 1'b0, 11'd2);
        fork
            feed_tx(32'h0000_3CA5, 2);
            wait_done(2000, 1'b0, el);
        join
        check_wlog("wr", base, '{19'h30400, 19'h10040, 19'h100A5, 19'h1003C, 19'h30000});
        check_eq("wr_no_rx", 32'(rx_log.size() - rbase), 32'd0);
        @(negedge clk);
        check_eq("idle_after_done", {30'b0, busy, cmd_ready}, 32'b01);

        // Read with dummy: op, dummy and payload return 0x11, 0x22, 0x33.
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
        base = wr_addr.size(); rbase = rx_log.size();
        issue(8'h1F, 1'b1, 1'b1, 11'd1);
        wait_done(2000, 1'b0, el);
        check_wlog("rdd", base, '{19'h30400, 19'h1001F, 19'h10000, 19'h10000, 19'h30000});
        check_eq("rdd_nrx", 32'(rx_log.size() - rbase), 32'd1);
        if (rx_log.size() > rbase) check_eq("rdd_rx0", {24'b0, rx_log[rbase]}, 32'h33);

        // Backpressure on a 3-byte read: rx_data holds, no further DATA_TX write.
        resp[0] = 8'h99; resp[1] = 8'h5A; resp[2] = 8'h6B; resp[3] = 8'h7C;
        rx_ready = 1'b0;
        base = wr_addr.size(); rbase = rx_log.size();
        issue(8'h0B, 1'b0, 1'b1, 11'd3);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_valid) begin seen = 1'b1; break; end
        end
        check_eq("bp_rx_valid", 32'(seen), 32'd1);
        d0 = rx_data;
        check_eq("bp_rx_first", {24'b0, d0}, 32'h5A);
        check_eq("bp_nwr_at_valid", 32'(wr_addr.size() - base), 32'd3);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!rx_valid || rx_data !== d0) bad++;
        end
        check_eq("bp_rx_stable", bad, 32'd0);
        check_eq("bp_nwr_held", 32'(wr_addr.size() - base), 32'd3);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        wait_done(2000, 1'b0, el);
        check_wlog("bp", base, '{19'h30400, 19'h1000B, 19'h10000, 19'h10000, 19'h10000, 19'h30000});
        check_eq("bp_nrx", 32'(rx_log.size() - rbase), 32'd3);
        if (rx_log.size() >= rbase + 3) begin
            check_eq("bp_rx1", {24'b0, rx_log[rbase+1]}, 32'h6B);
            check_eq("bp_rx2", {24'b0, rx_log[rbase+2]}, 32'h7C);
        end

        // Timeout: rrdy never rises, frame is closed and err reported.
        hold_rrdy = 1'b1;
        base = wr_addr.size();
        issue(8'h05, 1'b0, 1'b0, 11'd0);
        wait_done(TMO + 200, 1'b1, el);
        check_eq("tmo_window", 32'(el >= TMO && el <= TMO + 30), 32'd1);
        check_wlog("tmo", base, '{19'h30400, 19'h10005, 19'h30000});
        hold_rrdy = 1'b0;
        @(negedge clk);
        check_eq("tmo_err_cleared", 32'(err), 32'd0);

        // Reset during the payload byte, then a normal command.
        base = wr_addr.size();
        issue(8'h40, 1'b0, 1'b0, 11'd1);
        tx_data = 8'h77; tx_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wr_addr.size() >= base + 3) begin seen = 1'b1; break; end
        end
        check_eq("mid_payload_reached", 32'(seen), 32'd1);
        tx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        base = wr_addr.size();
        issue(8'h02, 1'b0, 1'b0, 11'd1);
        fork
            feed_tx(32'h0000_0099, 1);
            wait_done(2000, 1'b0, el);
        join
        check_wlog("post", base, '{19'h30400, 19'h10002, 19'h10099, 19'h30000});

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lan_spi_cmd_seq.md
# lan_spi_cmd_seq

Command sequencer that sits directly upstream of the LAN SPI master core and drives its register port. It turns one framed transaction (opcode byte, optional dummy byte, N payload bytes) into the core's two-cycle register accesses. It streams payload in from a TX byte interface, or out to an RX byte interface. Slave select is held asserted for the whole frame through the core's SSO control bit.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum clocks to wait for `spi_trdy` or `spi_rrdy` before aborting.
- LEN_W, 11: width of the payload byte count.

Ports:
- `clk` in 1: system clock (same clock as the SPI core).
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 8: first byte shifted out.
- `cmd_dummy` in 1: insert one discarded 0x00 byte after `cmd_op`.
- `cmd_rd` in 1: 1 = payload received to RX; 0 = payload sent from TX.
- `cmd_len` in LEN_W: payload byte count; 0 is legal.
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: payload source.
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: payload sink.
- `busy` out 1: high from command accept through the done pulse.
- `done` out 1: one-cycle pulse when the transaction ends.
- `err` out 1: qualified by `done`; set on timeout.
- `spi_select` out 1, `spi_read_n` out 1, `spi_write_n` out 1, `spi_addr` out 3, `spi_wdata` out 16: core register port.
- `spi_rdata` in 16, `spi_trdy` in 1, `spi_rrdy` in 1: core read data, readyfordata, dataavailable.

Reset values:
- `cmd_ready` 0. It rises on the first cycle after reset release.
- `tx_ready`, `rx_valid`, `busy`, `done`, `err`, `spi_select` are all 0.
- `spi_read_n` and `spi_write_n` are 1.
- `spi_addr` and `spi_wdata` are 0. `rx_data` is 0.

## Operation
- Register addresses: DATA_RX=0, DATA_TX=1, STATUS=2, CONTROL=3. The CONTROL SSO bit is bit 10.
- Bus access, fixed shape:
  - `spi_select`=1 with the strobe low for exactly 2 cycles, then at least 1 idle cycle.
  - Longer assertion is forbidden because the core re-strobes.
  - Read data is sampled from `spi_rdata` on the edge ending access cycle 2.
- States: IDLE, SS_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, RX_PUSH, SS_OFF, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command and go to SS_ON.
- SS_ON: write CONTROL=0x0400, then go to TX_WAIT.
- TX_WAIT: wait for `spi_trdy`.
  - For TX-payload bytes, also wait for `tx_valid`; `tx_ready` pulses for 1 cycle as the byte is taken.
  - Byte order: `cmd_op`, then dummy (if `cmd_dummy`), then payload.
  - Payload bytes are `tx_data` when `cmd_rd`=0, else 0x00.
- TX_WR: write DATA_TX with {8'h00, byte}, then go to RX_WAIT.
- RX_WAIT: wait for `spi_rrdy`, then go to RX_RD.
- RX_RD: read DATA_RX.
  - Op and dummy bytes, and all bytes when `cmd_rd`=0: discard.
  - Otherwise go to RX_PUSH.
- RX_PUSH: `rx_valid`=1 holding `rx_data` until `rx_ready`. The next byte is not issued until then.
- After each byte's receive: if bytes remain, go to TX_WAIT; else go to SS_OFF.
- SS_OFF: write CONTROL=0x0000, then DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- Only one byte is in flight at a time, so the core never sees TOE or ROE.

## Timing
- Command accept to first access: 1 cycle.
- Each access occupies 3 cycles (2 active + 1 gap).
- Per byte: TX access, then about 90 cycles of core shift (5-clock divider × 18 states), then RX access.
- Minimum total: 2 + 3 + B×(6 + shift + wait) + 3 + 1 cycles, where B = 1 + `cmd_dummy` + `cmd_len`.
- `cmd_len`=0 with no dummy: exactly one byte (the opcode) is sent.
- Timeout:
  - Applies in TX_WAIT/RX_WAIT when the counter reaches TIMEOUT_CYCLES.
  - It does not apply while waiting on `tx_valid` or `rx_ready`.
  - On timeout go to SS_OFF, then DONE with `err`=1.
- `cmd_valid` while busy: ignored (`cmd_ready`=0).
- `reset` mid-transaction: outputs go to reset values immediately. The SPI core shares the reset net (inverted at top level), so SS releases too.

## Structure
- Shared package `lan_spi_pkg`: register address constants, SSO bit index, state enum, SHIFT_CYCLES=90 (for bench timing).
- One sub-module `lan_spi_bus_access`:
  - Inputs: start, rd/wr, addr, wdata.
  - Outputs: busy, rdata_valid, rdata.
  - Owns the 2+1 cycle access shape.
- The sequencer FSM, byte counter, and timeout counter live in the top.

## Test plan
- Write command: op=0x40, `cmd_len`=2, TX 0xA5,0x3C.
  - Required: DATA_TX writes 0x0040, 0x00A5, 0x003C.
  - CONTROL writes 0x0400 first and 0x0000 last.
  - No `rx_valid`; `done` with `err`=0.
- Read command with dummy: op=0x1F, `cmd_dummy`=1, `cmd_len`=1, model returns 0x11,0x22,0x33.
  - Required: exactly one `rx_valid` with `rx_data`=0x33.
- Access shape: check every read/write.
  - `spi_select` low-strobe is exactly 2 cycles, with at least 1 idle cycle between accesses.
- Backpressure: hold `rx_ready`=0 for 50 cycles on a 3-byte read.
  - `rx_data` is stable.
  - No DATA_TX write occurs until acceptance.
- Timeout: model holds `spi_rrdy`=0.
  - CONTROL=0x0000 is written.
  - `done`=1 with `err`=1 at TIMEOUT_CYCLES + a few cycles.
- Reset asserted during the payload byte: all outputs reach reset values within the same cycle; the next command completes normally.
